// File: rtl/k16_text_renderer.sv
// k16_text_renderer
// -----------------------------------------------------------------------------
// Text-mode pixel pipeline sitting between the VGA timing generator and the
// pins. The screen is a 40x30 grid of 16x16-pixel cells; each cell holds a
// 16-bit word {blink, reserved, bg[2:0], fg[2:0], char[7:0]} and is drawn from an
// 8x8 glyph doubled in both axes. One clock is one pixel, and the pipeline
// advances on every clock with no stalls.
//
// Pipeline (each input pixel reaches the pins 5 register stages later):
//   edge 0 : fb_raddr  <= row*40 + col
//   edge 1 : external frame-buffer RAM registers the cell (fb_rdata)
//   edge 2 : font_addr <= {char, glyph_row}; attribute bits captured
//   edge 3 : external font ROM registers the glyph row (font_data)
//   edge 4 : RGB register (blink, foreground/background, blanking)
// hsync/vsync/active ride along in matching shift registers.
//
// Ports:
//   clk, reset_n                 pixel clock, synchronous active-low reset
//   in_h, in_v                   pixel / line counters from the timing generator
//   in_active                    1 = visible pixel
//   in_hsync, in_vsync           active-low syncs from the timing generator
//   fb_raddr / fb_rdata          frame-buffer read port (1-cycle latency)
//   font_addr / font_data        font ROM port (1-cycle latency), bit 7 leftmost
//   vga_r, vga_g, vga_b          pixel colour
//   vga_hsync, vga_vsync         syncs delayed to line up with the colour
// -----------------------------------------------------------------------------
module k16_text_renderer #(
    parameter int FB_ADDR_WIDTH = 11,
    parameter int COLS          = 40,
    parameter int BLINK_BIT     = 5,
    parameter int LATENCY       = 5   // the RGB path is fixed at this depth
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [9:0]               in_h,
    input  logic [9:0]               in_v,
    input  logic                     in_active,
    input  logic                     in_hsync,
    input  logic                     in_vsync,
    output logic [FB_ADDR_WIDTH-1:0] fb_raddr,
    input  logic [15:0]              fb_rdata,
    output logic [10:0]              font_addr,
    input  logic [7:0]               font_data,
    output logic                     vga_r,
    output logic                     vga_g,
    output logic                     vga_b,
    output logic                     vga_hsync,
    output logic                     vga_vsync
);

    localparam int AW = FB_ADDR_WIDTH;

    // ---------------------------------------------------------------------
    // Stage 0 address arithmetic. Out-of-range counters are not clamped:
    // they produce some in-range address whose pixels are blanked later.
    // ---------------------------------------------------------------------
    logic [11:0]   row_x;
    logic [11:0]   col_x;
    logic [AW-1:0] cell_addr;

    assign row_x = {7'd0, in_v[8:4]};
    assign col_x = {6'd0, in_h[9:4]};

    // The 40-column stride is built as row*32 + row*8; any other stride
    // falls back to a constant multiply.
    assign cell_addr = (COLS == 40)
                     ? AW'((row_x << 5) + (row_x << 3) + col_x)
                     : AW'(row_x * 12'(COLS) + col_x);

    // ---------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------
    logic [2:0]         glyph_row_1, glyph_row_2;
    logic [2:0]         pix_idx_1, pix_idx_2, pix_idx_3, pix_idx_4;
    logic [6:0]         attr_3, attr_4;           // {blink, bg[2:0], fg[2:0]}
    logic [LATENCY-2:0] active_sr;                // last stage is the RGB register
    logic [LATENCY-1:0] hsync_sr;
    logic [LATENCY-1:0] vsync_sr;
    logic [2:0]         rgb_q;
    logic               vsync_q;
    logic [5:0]         frame_cnt;

    // Bits the cell format and the doubled-pixel addressing never look at.
    logic unused_bits;
    assign unused_bits = ^{in_h[0], in_v[0], in_v[9], fb_rdata[14]};

    logic       pix;
    logic [2:0] colour;

    // NOTE: every register here uses <= so all stages sample the values from
    // before the edge; blocking assignments would collapse the pipeline.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the whole delay line is reset, not just the control bits,
            // so nothing fetched before reset can leak onto the pins afterwards.
            fb_raddr    <= '0;
            glyph_row_1 <= '0;
            glyph_row_2 <= '0;
            pix_idx_1   <= '0;
            pix_idx_2   <= '0;
            pix_idx_3   <= '0;
            pix_idx_4   <= '0;
            font_addr   <= '0;
            attr_3      <= '0;
            attr_4      <= '0;
            active_sr   <= '0;
            hsync_sr    <= '1;
            vsync_sr    <= '1;
            rgb_q       <= '0;
            vsync_q     <= 1'b1;
            frame_cnt   <= '0;
        end else begin
            // Stage 0: cell address plus the sub-cell coordinates
            fb_raddr    <= cell_addr;
            glyph_row_1 <= in_v[3:1];
            pix_idx_1   <= in_h[3:1];

            // Stage 1: RAM is reading the cell
            glyph_row_2 <= glyph_row_1;
            pix_idx_2   <= pix_idx_1;

            // Stage 2: cell available; launch the glyph fetch
            font_addr   <= {fb_rdata[7:0], glyph_row_2};
            attr_3      <= {fb_rdata[15], fb_rdata[13:8]};
            pix_idx_3   <= pix_idx_2;

            // Stage 3: ROM is reading the glyph row
            attr_4      <= attr_3;
            pix_idx_4   <= pix_idx_3;

            // Stage 4: final colour
            rgb_q       <= colour;

            active_sr   <= {active_sr[LATENCY-3:0], in_active};
            hsync_sr    <= {hsync_sr[LATENCY-2:0], in_hsync};
            vsync_sr    <= {vsync_sr[LATENCY-2:0], in_vsync};

            // One count per frame, on the falling edge of the input vsync.
            vsync_q     <= in_vsync;
            if (vsync_q && !in_vsync) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    // Stage 4 pixel select. Bit 7 of the glyph row is the leftmost pixel,
    // so the bit index is 7 - pix_idx, i.e. the inverted 3-bit index.
    // NOTE: pix and colour get a value before any condition is tested, so
    // every path assigns them and no latch can be inferred.
    always_comb begin
        pix    = font_data[~pix_idx_4];
        colour = 3'b000;
        if (attr_4[6] && frame_cnt[BLINK_BIT]) begin
            pix = 1'b0;
        end
        if (active_sr[LATENCY-2]) begin
            colour = pix ? attr_4[2:0] : attr_4[5:3];
        end
    end

    assign vga_r     = rgb_q[2];
    assign vga_g     = rgb_q[1];
    assign vga_b     = rgb_q[0];
    assign vga_hsync = hsync_sr[LATENCY-1];
    assign vga_vsync = vsync_sr[LATENCY-1];

endmodule

// File: tb/tb_k16_text_renderer.sv
// Bench for k16_text_renderer: external frame-buffer RAM and font ROM are
// modelled as arrays with registered reads; expected outputs come from a
// per-pixel reference computed directly from the cell/glyph rules.
module tb_k16_text_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  in_h, in_v;
    logic        in_active, in_hsync, in_vsync;
    logic [10:0] fb_raddr;
    logic [15:0] fb_rdata;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        vga_r, vga_g, vga_b, vga_hsync, vga_vsync;

    always #5 clk = ~clk;

    k16_text_renderer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_h      (in_h),
        .in_v      (in_v),
        .in_active (in_active),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .fb_raddr  (fb_raddr),
        .fb_rdata  (fb_rdata),
        .font_addr (font_addr),
        .font_data (font_data),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync)
    );

    // External memories with one-cycle registered reads
    logic [15:0] fb_mem   [2048];
    logic [7:0]  font_rom [2048];

    always_ff @(posedge clk) begin
        fb_rdata  <= fb_mem[fb_raddr];
        font_data <= font_rom[font_addr];
    end

    // Reference model state
    typedef struct {
        int h;
        int v;
        bit active;
        bit hs;
        bit vs;
        bit valid;   // 0 = reset filler entry or memory changed while in flight
    } rec_t;

    rec_t q[$];          // last five sampled pixels, oldest first
    int   fc;            // model frame counter
    bit   prev_vs;
    int   checks   = 0;
    int   failures = 0;

    function automatic int addr_of(int h, int v);
        return ((((v / 16) % 32) * 40) + ((h / 16) % 64)) % 2048;
    endfunction

    function automatic logic [2:0] colour_of(rec_t o, int f);
        logic [15:0] c;
        logic [7:0]  g;
        logic [2:0]  grow;
        bit          p;
        c    = fb_mem[addr_of(o.h, o.v)];
        grow = 3'((o.v / 2) % 8);
        g    = font_rom[{c[7:0], grow}];
        p    = g[7 - ((o.h / 2) % 8)];
        if (c[15] && f >= 32) p = 1'b0;   // blink-off half of the 64-frame cycle
        return p ? c[10:8] : c[13:11];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic invalidate_inflight();
        foreach (q[i]) q[i].valid = 1'b0;
    endtask

    // One pixel clock: drive inputs at the falling edge, let the rising edge
    // happen, update the model, then compare at the next falling edge.
    task automatic step(input int h, input int v, input int act, input int hs, input int vs);
        rec_t       r, o, o2;
        logic [2:0] rgb_want;
        logic [10:0] fa_want;
        bit         in_reset;
        bit         fa_chk;
        in_h      = 10'(h);
        in_v      = 10'(v);
        in_active = (act != 0);
        in_hsync  = (hs != 0);
        in_vsync  = (vs != 0);
        in_reset  = !reset_n;
        @(posedge clk);
        if (in_reset) begin
            q.delete();
            repeat (5) q.push_back('{h: 0, v: 0, active: 1'b0, hs: 1'b1, vs: 1'b1, valid: 1'b0});
            fc      = 0;
            prev_vs = 1'b1;
            @(negedge clk);
            check("rst_rgb",   16'({vga_r, vga_g, vga_b}), 16'd0);
            check("rst_hsync", 16'(vga_hsync), 16'd1);
            check("rst_vsync", 16'(vga_vsync), 16'd1);
            check("rst_fb_raddr", 16'(fb_raddr), 16'd0);
            check("rst_font_addr", 16'(font_addr), 16'd0);
        end else begin
            r = '{h: h, v: v, active: (act != 0), hs: (hs != 0), vs: (vs != 0), valid: 1'b1};
            q.push_back(r);
            if (q.size() > 5) q.delete(0);
            o  = q[0];
            o2 = q[2];
            rgb_want = o.active ? colour_of(o, fc) : 3'b000;
            fa_chk   = o2.valid;
            fa_want  = {fb_mem[addr_of(o2.h, o2.v)][7:0], 3'((o2.v / 2) % 8)};
            if (prev_vs && vs == 0) fc = (fc + 1) % 64;
            prev_vs = (vs != 0);
            @(negedge clk);
            if (o.valid || !o.active) check("rgb", 16'({vga_r, vga_g, vga_b}), 16'(rgb_want));
            check("hsync", 16'(vga_hsync), 16'(o.hs));
            check("vsync", 16'(vga_vsync), 16'(o.vs));
            check("fb_raddr", 16'(fb_raddr), 16'(addr_of(h, v)));
            if (fa_chk) check("font_addr", 16'(font_addr), 16'(fa_want));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1);
    endtask

    task automatic vsync_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 1, 1);
        end
    endtask

    task automatic scan_cell0();
        for (int h = 0; h < 16; h++) step(h, 0, 1, 1, 1);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 2048; i++) begin
            fb_mem[i]   = 16'($urandom);
            font_rom[i] = 8'($urandom);
        end
        invalidate_inflight();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            fb_mem[i]   = 16'h0000;
            font_rom[i] = 8'h00;
        end
        fc      = 0;
        prev_vs = 1'b1;

        // Reset held with active pixels and asserted syncs at the inputs
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        idle(5);

        // Latency and colour: 'H', fg 111, bg 100, glyph row 0x81
        fb_mem[0]               = 16'h2748;
        font_rom[{8'h48, 3'd0}] = 8'h81;
        invalidate_inflight();
        scan_cell0();
        idle(5);

        // Address arithmetic at the grid corners
        step(624, 464, 0, 1, 1);
        step(0, 16, 0, 1, 1);
        step(1023, 1023, 0, 1, 1);
        idle(5);

        // Blanking window and hsync edges travelling through the delay line
        fb_mem[0]               = 16'h3F41;
        font_rom[{8'h41, 3'd0}] = 8'hA5;
        invalidate_inflight();
        for (int h = 0; h < 16; h++)
            step(h, 0, (h >= 4 && h < 12) ? 1 : 0, (h >= 6 && h < 10) ? 0 : 1, 1);
        idle(5);

        // Reset in the middle of a line, after a few frames have counted
        randomize_mem();
        idle(5);
        vsync_pulses(3);
        for (int h = 290; h < 310; h++) begin
            reset_n = (h != 300);
            step(h, 100, 1, 1, 1);
        end
        reset_n = 1'b1;
        idle(5);

        // Blink: fg 100 / bg 001, solid glyph
        fb_mem[0] = 16'h8C57;
        for (int r = 0; r < 8; r++) font_rom[{8'h57, 3'(r)}] = 8'hFF;
        invalidate_inflight();
        scan_cell0();
        vsync_pulses(32);
        scan_cell0();
        vsync_pulses(32);
        scan_cell0();
        idle(5);

        // Randomized traffic over the whole counter range
        randomize_mem();
        idle(5);
        for (int i = 0; i < 400; i++)
            step(int'($urandom_range(1023)), int'($urandom_range(1023)),
                 int'($urandom_range(3) != 0), int'($urandom_range(7) != 0),
                 int'($urandom_range(15) != 0));
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
